irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller driving the MIPS core's irq/irq_addr/irq_ack interface; the requesting side of the protocol the core answers.
- Latches rising edges on NSRC interrupt sources and keeps them pending.
- Picks the highest-priority unmasked pending source and presents its exception-memory vector to the core.
- Holds off further requests until the core reports ISR completion; a small word-addressed register port gives mask/pending/force/status access.

Parameters:
NSRC, 4, number of interrupt sources (1..16)
VEC_BASE, 32'h0, vector address of source 0
VEC_STRIDE, 32'h20, byte spacing between vectors (source k -> VEC_BASE + k*VEC_STRIDE)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
src  in  NSRC  interrupt sources, synchronous to clk, rising-edge triggered
irq  out  1  interrupt request to core
irq_addr  out  32  vector of the requested source; valid while irq=1
irq_ack  in  1  core accepts request (sampled only in REQ)
irq_done  in  1  one-cycle pulse: core finished ISR / restored context (sampled only in SERVICE)
we  in  1  register write enable
addr  in  4  register byte address; addr[3:2] selects register
wd  in  32  register write data
rd  out  32  register read data, combinational from addr
active_id  out  4  index of source in REQ/SERVICE; 0 when IDLE

Behaviour:
- Reset (rst=0, asynchronous) sets: state=IDLE, irq=0, irq_addr=0, active_id=0, pending=0, src_q=0, mask=all ones (all enabled).
- Edge detect: rise[k]=src[k]&~src_q[k]; src_q<=src every cycle. A rise sets pending[k] at that clock edge. A source held high gives one event only.
- Pending update priority per bit: set (rise or FORCE write) wins over clear (ack or W1C). The bit stays 1 after a simultaneous set and clear.
- Selection: candidate = pending & mask. Winner = lowest set index (source 0 has highest priority).
- State IDLE:
  - If candidate != 0, go to REQ at the next edge and register irq=1, irq_addr=VEC_BASE+winner*VEC_STRIDE (32-bit, wraps modulo 2^32), active_id=winner.
  - Latency: src rises before edge t, pending is set at t, irq is high after t+1.
- State REQ:
  - irq and irq_addr are held stable; the request is committed and is not withdrawn by later masking or a higher-priority arrival.
  - When irq_ack=1 at an edge: clear pending[active_id], set irq=0, go to SERVICE.
- State SERVICE:
  - No requests issued (non-nested); new rises are still latched into pending.
  - When irq_done=1 at an edge: go to IDLE, active_id=0.
  - The earliest next irq is one cycle after returning to IDLE.
- irq_ack outside REQ and irq_done outside SERVICE are ignored.
- Registers (addr[3:2]); unused high bits read 0:
  - 0 MASK: read/write; bit k=1 enables source k.
  - 1 PENDING: read; writing 1 to bit k clears it (W1C).
  - 2 FORCE: write 1 sets pending[k]; reads 0.
  - 3 STATUS: {26'b0, state[1:0], active_id[3:0]}, with IDLE=0, REQ=1, SERVICE=2.
- Writes take effect at the edge. A MASK write and the selection in the same cycle use the old mask.
- Reset asserted mid-REQ/SERVICE: irq drops immediately and all pending events are lost.

Test Plan:
- Reset: rst=0 -> irq=0, irq_addr=0, rd@addr 0=0xF, rd@addr 4=0, STATUS=0.
- src[1] rises -> irq=1 two edges later with irq_addr=0x20, active_id=1, STATUS=0x11. irq_ack one cycle -> irq=0, STATUS=0x21, PENDING=0. irq_done -> STATUS=0.
- src[0] and src[2] rise in the same cycle -> first request irq_addr=0x0. After ack/done, the next request is irq_addr=0x40 with no extra source activity.
- MASK=0x7, src[3] rises -> no irq and PENDING=0x8. Write MASK=0xF -> irq with irq_addr=0x60.
- src[1] rises again during SERVICE of source 1 -> PENDING=0x2, no irq until irq_done, then re-request at 0x20. Rise coinciding with ack -> pending stays 1.
- Write FORCE=0x4 in IDLE -> irq_addr=0x40. Hold irq_ack=0 for 10 cycles -> irq and irq_addr stay stable. Pulse rst=0 -> irq=0 within the same cycle.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, priority-encoded interrupt requester for a core
// with an irq/irq_addr/irq_ack handshake and an irq_done completion pulse.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-low reset
//   src        NSRC interrupt sources, rising-edge triggered
//   irq        registered interrupt request to the core
//   irq_addr   vector of the requested source (valid while irq=1)
//   irq_ack    core accepts the request (looked at only in REQ)
//   irq_done   core finished the ISR (looked at only in SERVICE)
//   we         register write enable
//   addr       register byte address; addr[3:2] selects the register
//   wd         register write data
//   rd         register read data, combinational from addr
//   active_id  source being requested/serviced, 0 when idle
//
// Register map (addr[3:2]): 0 MASK rw, 1 PENDING r/W1C,
// 2 FORCE w (reads 0), 3 STATUS {26'b0, state, active_id}.
module irq_ctrl #(
    parameter int          NSRC       = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0,
    parameter logic [31:0] VEC_STRIDE = 32'h20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    output logic            irq,
    output logic [31:0]     irq_addr,
    input  logic            irq_ack,
    input  logic            irq_done,
    input  logic            we,
    input  logic [3:0]      addr,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic [3:0]      active_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] set_v;
    logic [NSRC-1:0] clr_v;
    logic [NSRC-1:0] ack_v;
    logic [NSRC-1:0] pending_n;
    logic [3:0]      win;
    logic [31:0]     vec;
    logic [1:0]      sel;

    // Address bits below the word select and write data above NSRC
    // carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wd[31:NSRC]};

    assign sel   = addr[3:2];
    assign rise  = src & ~src_q;
    assign cand  = pending & mask;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win = 4'd0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (cand[k]) win = 4'(k);
        end
    end

    assign vec = VEC_BASE + 32'(win) * VEC_STRIDE;

    always_comb begin
        ack_v = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (state == REQ && irq_ack && active_id == 4'(k)) ack_v[k] = 1'b1;
        end
    end

    assign set_v = rise | ((we && sel == 2'd2) ? wd[NSRC-1:0] : '0);
    assign clr_v = ack_v | ((we && sel == 2'd1) ? wd[NSRC-1:0] : '0);

    // A set in the same cycle as a clear must survive.
    assign pending_n = (pending & ~clr_v) | set_v;

    always_comb begin
        rd = '0;
        unique case (sel)
            2'd0: rd[NSRC-1:0] = mask;
            2'd1: rd[NSRC-1:0] = pending;
            2'd2: rd = '0;
            2'd3: rd = {26'b0, state, active_id};
            default: rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '1;
        end else begin
            src_q   <= src;
            pending <= pending_n;
            if (we && sel == 2'd0) mask <= wd[NSRC-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            irq       <= 1'b0;
            irq_addr  <= '0;
            active_id <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|cand) begin
                        state     <= REQ;
                        irq       <= 1'b1;
                        irq_addr  <= vec;
                        active_id <= win;
                    end
                end
                REQ: begin
                    // Committed: only the ack releases the request.
                    if (irq_ack) begin
                        state <= SERVICE;
                        irq   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        state     <= IDLE;
                        active_id <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src = '0;
    logic        irq;
    logic [31:0] irq_addr;
    logic        irq_ack = 1'b0;
    logic        irq_done = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic [3:0]  active_id;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl #(
        .NSRC      (4),
        .VEC_BASE  (32'h0),
        .VEC_STRIDE(32'h20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .irq      (irq),
        .irq_addr (irq_addr),
        .irq_ack  (irq_ack),
        .irq_done (irq_done),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .active_id(active_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string tag, input logic [3:0] a,
                         input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wd = d;
        tick();
        we = 1'b0;
        wd = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic done();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
    endtask

    initial begin
        // Reset
        #1 rst = 1'b0;
        #1;
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_addr", irq_addr, 32'h0);
        rdchk("rst_mask", 4'h0, 32'hF);
        rdchk("rst_pend", 4'h4, 32'h0);
        rdchk("rst_stat", 4'hC, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Single source 1
        src = 4'b0010;
        tick();
        chk("s1_irq_early", 32'(irq), 32'h0);
        rdchk("s1_pend", 4'h4, 32'h2);
        tick();
        chk("s1_irq", 32'(irq), 32'h1);
        chk("s1_addr", irq_addr, 32'h20);
        chk("s1_id", 32'(active_id), 32'h1);
        rdchk("s1_stat_req", 4'hC, 32'h11);
        ack();
        chk("s1_irq_ack", 32'(irq), 32'h0);
        rdchk("s1_stat_svc", 4'hC, 32'h21);
        rdchk("s1_pend_clr", 4'h4, 32'h0);
        done();
        rdchk("s1_stat_idle", 4'hC, 32'h0);
        tick();
        tick();
        chk("s1_held_once", 32'(irq), 32'h0);
        src = '0;
        tick();

        // Sources 0 and 2 together
        src = 4'b0101;
        tick();
        tick();
        chk("s02_irq", 32'(irq), 32'h1);
        chk("s02_addr0", irq_addr, 32'h0);
        ack();
        done();
        tick();
        chk("s02_irq2", 32'(irq), 32'h1);
        chk("s02_addr2", irq_addr, 32'h40);
        chk("s02_id2", 32'(active_id), 32'h2);
        ack();
        done();
        src = '0;
        tick();

        // Masked source 3
        wr(4'h0, 32'h7);
        src = 4'b1000;
        tick();
        tick();
        tick();
        chk("m3_noirq", 32'(irq), 32'h0);
        rdchk("m3_pend", 4'h4, 32'h8);
        rdchk("m3_mask", 4'h0, 32'h7);
        wr(4'h0, 32'hF);
        chk("m3_oldmask", 32'(irq), 32'h0);
        tick();
        chk("m3_irq", 32'(irq), 32'h1);
        chk("m3_addr", irq_addr, 32'h60);
        ack();
        done();
        src = '0;
        tick();

        // Re-rise during service, and rise coinciding with ack
        src = 4'b0010;
        tick();
        tick();
        ack();
        src = '0;
        tick();
        src = 4'b0010;
        tick();
        rdchk("rr_pend", 4'h4, 32'h2);
        chk("rr_noirq", 32'(irq), 32'h0);
        tick();
        chk("rr_noirq2", 32'(irq), 32'h0);
        done();
        chk("rr_noirq3", 32'(irq), 32'h0);
        tick();
        chk("rr_irq", 32'(irq), 32'h1);
        chk("rr_addr", irq_addr, 32'h20);
        src = '0;
        tick();
        src = 4'b0010;
        ack();
        rdchk("ra_pend", 4'h4, 32'h2);
        rdchk("ra_stat", 4'hC, 32'h21);
        done();
        tick();
        chk("ra_irq", 32'(irq), 32'h1);
        chk("ra_addr", irq_addr, 32'h20);
        ack();
        done();
        src = '0;
        tick();
        rdchk("ra_pend_clr", 4'h4, 32'h0);

        // Force, hold without ack, then reset mid-request
        wr(4'h8, 32'h4);
        rdchk("f_read0", 4'h8, 32'h0);
        rdchk("f_pend", 4'h4, 32'h4);
        tick();
        chk("f_irq", 32'(irq), 32'h1);
        chk("f_addr", irq_addr, 32'h40);
        irq_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("f_hold_irq", 32'(irq), 32'h1);
            chk("f_hold_addr", irq_addr, 32'h40);
        end
        irq_done = 1'b0;
        rdchk("f_stat", 4'hC, 32'h12);
        rst = 1'b0;
        #1;
        chk("rst_mid_irq", 32'(irq), 32'h0);
        chk("rst_mid_addr", irq_addr, 32'h0);
        rdchk("rst_mid_pend", 4'h4, 32'h0);
        rdchk("rst_mid_stat", 4'hC, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
